// File: rtl/filter_frame_ctrl.sv
// Frame sequencer: streams a source frame through the external filter bank
// into the destination frame buffer, one pixel per granted cycle.
module filter_frame_ctrl #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              src_gnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [1:0]        flt_sel,
    output logic [PIX_W-1:0]  flt_pix_in,
    input  logic [PIX_W-1:0]  flt_pix_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pix_cnt
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic              r_valid1;
    logic              r_valid2;
    logic              r_wr_en;
    logic [1:0]        r_flt_sel;
    logic [PIX_W-1:0]  r_pix_in;
    logic [PIX_W-1:0]  r_wr_data;

    logic w_start_ok;
    logic w_rd_en;
    logic w_last_rd;
    logic w_pipe_empty;
    logic w_busy;
    logic w_done;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_last_rd    = w_rd_en && (r_rd_cnt == LAST);
    assign w_pipe_empty = !r_valid1 && !r_valid2 && !r_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last_rd) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pipe_empty) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // done fires once the last write has left stage 3; busy drops with it
    always_comb begin
        w_rd_en = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
            end
            S_RUN: begin
                w_rd_en = src_gnt;
                w_busy  = 1'b1;
            end
            S_DRAIN: begin
                w_busy = !w_pipe_empty;
                w_done = w_pipe_empty;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt  <= '0;
            r_flt_sel <= '0;
            r_pix_cnt <= '0;
        end else if (w_start_ok) begin
            r_rd_cnt  <= '0;
            r_flt_sel <= mode;
            r_pix_cnt <= '0;
        end else begin
            if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (r_wr_en) r_pix_cnt <= r_pix_cnt + 1'b1;
        end
    end

    // three-stage read -> filter -> write pipeline, never stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid1  <= 1'b0;
            r_addr1   <= '0;
            r_valid2  <= 1'b0;
            r_addr2   <= '0;
            r_pix_in  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_valid1 <= w_rd_en;
            r_addr1  <= r_rd_cnt;
            r_valid2 <= r_valid1;
            if (r_valid1) begin
                r_pix_in <= rd_data;
                r_addr2  <= r_addr1;
            end
            r_wr_en   <= r_valid2;
            r_wr_addr <= r_addr2;
            r_wr_data <= flt_pix_out;
        end
    end

    assign rd_en      = w_rd_en;
    assign rd_addr    = r_rd_cnt;
    assign flt_sel    = r_flt_sel;
    assign flt_pix_in = r_pix_in;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = w_busy;
    assign done       = w_done;
    assign pix_cnt    = r_pix_cnt;

endmodule

// File: doc/filter_frame_ctrl.md
# filter_frame_ctrl

Frame-level sequencer for the pixel filter datapath in RGB444 (12-bit) image processing. On a start pulse it streams every pixel of a frame from the source frame buffer through the external combinational filter and writes each result to the destination frame buffer at the same address. Source-port access is gated by a grant from the display-read arbiter. The filter mode is latched per frame so a mid-frame switch change cannot corrupt an image.

## Interface
Parameters:
- H_RES, 320, active pixels per line
- V_RES, 240, lines per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES
- PIX_W, 12, pixel width ({R[11:8],G[7:4],B[3:0]})

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- mode  in  2  filter select, sampled only on an accepted start
- src_gnt  in  1  source BRAM port granted this cycle
- rd_en  out  1  source read strobe
- rd_addr  out  ADDR_W  source read address
- rd_data  in  PIX_W  source pixel, valid exactly 1 cycle after rd_en
- flt_sel  out  2  latched mode, to filter bank
- flt_pix_in  out  PIX_W  registered pixel to filter
- flt_pix_out  in  PIX_W  combinational filter result
- wr_en  out  1  destination write strobe
- wr_addr  out  ADDR_W  destination write address
- wr_data  out  PIX_W  destination pixel
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- pix_cnt  out  ADDR_W  pixels written in current/last frame

## Operation
- N = H_RES*V_RES; last address N-1.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 → latch mode into flt_sel, clear read counter and pix_cnt, busy=1, go RUN. Otherwise hold.
- RUN: rd_en = src_gnt (combinational from state and grant); rd_addr = read counter. On each cycle with rd_en=1 the counter increments. When a read of address N-1 is issued, go DRAIN.
- DRAIN: no reads; wait until the pipeline is empty, then pulse done, clear busy, go IDLE.
- Pipeline stage 1: valid1 <= rd_en, addr1 <= rd_addr (read counter delayed one cycle to align with rd_data).
- Stage 2: when valid1, flt_pix_in <= rd_data, addr2 <= addr1; valid2 <= valid1. flt_pix_in holds its value when valid1=0.
- Stage 3: wr_en <= valid2, wr_addr <= addr2, wr_data <= flt_pix_out. pix_cnt increments on each wr_en=1 cycle.
- Grant loss stalls only new reads. In-flight pixels always complete, because the destination port never back-pressures.
- start while busy is ignored: mode is not re-latched and counters are untouched.
- Mode encoding (filter bank): 0 bypass, 1 grayscale, 2 red-keep "sin city", 3 invert. The controller only forwards the latched value.
- Reset (asynchronous, any state): state IDLE; rd_en, wr_en, busy, done = 0; rd_addr, wr_addr, pix_cnt = 0; wr_data, flt_pix_in = 0; flt_sel = 0; valid flags cleared. A partially written frame is abandoned and no done is issued.

## Timing
- rd_en in cycle t → rd_data in t+1 → flt_pix_in in t+2 → wr_en/wr_addr/wr_data in t+3. Read-to-write latency is 3 cycles.
- Full grant: one pixel per cycle. A frame takes N + 3 cycles from the first rd_en to the last wr_en.
- Done timing:
  - done pulses in the cycle after the final wr_en.
  - busy falls in the same cycle done is asserted.
  - pix_cnt = N while done is high, and holds until the next accepted start.
- start accepted in cycle s → busy=1 and rd_en possible from s+1.
- start in the same cycle as done is ignored, since the block is not yet IDLE. start at s+1 after done is accepted.
- Address order is strictly ascending and wr_addr equals the matching rd_addr. There are no skips or duplicates under any grant pattern.

## Test plan
- Full frame, src_gnt=1, H_RES=4, V_RES=2, mode=2: source pixel 0xC32 → written 0xC00. Pixel 0x888 → 0x888 (grayscale path). Exactly 8 writes at addresses 0..7; done in cycle 12 after start; pix_cnt=8.
- Grant toggling 1,0,0,1,… with a random pattern: write sequence still 0..N-1 with data matching the filter model. rd_en is never high while src_gnt=0.
- Mode changed from 2 to 0 mid-frame, and start pulsed while busy: flt_sel stays 2 for the whole frame; no restart occurs; pix_cnt=N.
- rst_n low during RUN, after 3 reads: all outputs 0 immediately (asynchronous); no further wr_en; no done. A new start runs a clean frame from address 0.
- Back-to-back frames: start in the done cycle is ignored, start one cycle later is accepted. The second frame uses its newly latched mode=3, so 0x123 → 0xEDC.
- src_gnt=0 for 50 cycles after start: busy=1, no reads, no writes. When grant rises, the first rd_addr is 0.
